// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU op codes, datapath width and the
// multiply sequencer's state encoding.
package ex_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_SLL  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_SLT  = 4'd8,
    ALU_OP_NOPE = 4'd9,
    ALU_OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_mul_sequencer.sv
// Iterative radix-2 shift-add multiplier sequencer for the EX stage.
// Stalls the front of the pipeline for 33 cycles per MUL and presents the
// product for one cycle in DONE.
// Optional feature: define EX_MULH_EN for a 2*XLEN signed product with
// MULH (upper word) selection via mul_high.
module ex_mul_sequencer #(
  parameter int XLEN  = ex_pkg::XLEN,
  parameter int CNT_W = ex_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_start,
  input  logic [XLEN-1:0] mul_op1,
  input  logic [XLEN-1:0] mul_op2,
  input  logic            mul_high,
  input  logic            mul_flush,
  output logic            mul_stall,
  output logic            mul_busy,
  output logic            mul_done,
  output logic [XLEN-1:0] mul_result
);
  import ex_pkg::*;

`ifdef EX_MULH_EN
  localparam int ACC_W = 2 * XLEN;
`else
  localparam int ACC_W = XLEN;
`endif

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] mcand_q;
  logic [XLEN-1:0]  mplier_q;
  logic [ACC_W-1:0] acc_q;
  logic [XLEN-1:0]  res_q;

  logic             start_ok;
  logic             last_iter;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] prod_fin;
  logic [XLEN-1:0]  prod_word;
  logic [XLEN-1:0]  op1_ld;
  logic [XLEN-1:0]  op2_ld;

`ifdef EX_MULH_EN
  logic sign_q;
  logic high_q;
`endif

  assign start_ok  = mul_start && !mul_flush;
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

  // One shift-add step plus the final sign fix-up and word select
  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef EX_MULH_EN
    // Magnitudes go through the shift-add loop; the sign is restored on exit
    op1_ld    = mul_op1[XLEN-1] ? (~mul_op1 + 1'b1) : mul_op1;
    op2_ld    = mul_op2[XLEN-1] ? (~mul_op2 + 1'b1) : mul_op2;
    prod_fin  = sign_q ? (~acc_sum + 1'b1) : acc_sum;
    prod_word = high_q ? acc_q[ACC_W-1:XLEN] : acc_q[XLEN-1:0];
`else
    // Low word is sign-agnostic, so raw bit patterns are multiplied
    op1_ld    = mul_op1;
    op2_ld    = mul_op2;
    prod_fin  = acc_sum;
    prod_word = acc_q;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; flush in DONE suppresses the pulse
  always_comb begin
    state_d    = state_q;
    mul_stall  = 1'b0;
    mul_busy   = (state_q != IDLE);
    mul_done   = 1'b0;
    mul_result = res_q;
    case (state_q)
      IDLE: begin
        mul_stall = start_ok;
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        mul_stall = 1'b1;
        if (mul_flush)      state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (!mul_flush) begin
          mul_done   = 1'b1;
          mul_result = prod_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, shift-add iteration and result hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
`ifdef EX_MULH_EN
      sign_q   <= 1'b0;
      high_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start_ok) begin
          cnt_q    <= '0;
          mcand_q  <= ACC_W'(op1_ld);
          mplier_q <= op2_ld;
          acc_q    <= '0;
`ifdef EX_MULH_EN
          sign_q   <= mul_op1[XLEN-1] ^ mul_op2[XLEN-1];
          high_q   <= mul_high;
`endif
        end
        RUN: if (!mul_flush) begin
          acc_q    <= last_iter ? prod_fin : acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        DONE: if (!mul_flush) res_q <= prod_word;
        default: ;
      endcase
    end
  end

`ifndef EX_MULH_EN
  // mul_high only matters for the upper-word product
  logic unused_high;
  assign unused_high = mul_high;
`endif

endmodule
